// File: rtl/acc16_fetch_queue.sv
// acc16_fetch_queue: instruction fetch stage for pipeAcc16.
// Owns the PC, issues sequential reads to a one-cycle-latency instruction
// memory and buffers {instruction, pc} pairs in a small circular queue that
// feeds decode over a valid/ready handshake. Supports redirect, halt and
// backpressure.
module acc16_fetch_queue #(
   parameter int unsigned    DEPTH    = 4,
   parameter int unsigned    AW       = 16,
   parameter logic [AW-1:0]  RESET_PC = 16'h0000
) (
   input  logic                         clk1,
   input  logic                         rst,
   output logic                         imem_req,
   output logic [AW-1:0]                imem_addr,
   input  logic [15:0]                  imem_rdata,
   input  logic                         redirect,
   input  logic [AW-1:0]                redirect_pc,
   input  logic                         halt,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [15:0]                  out_ir,
   output logic [AW-1:0]                out_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [AW-1:0]  r_pc;
   logic           r_inflight;
   logic [AW-1:0]  r_inflight_pc;
   logic [15:0]    r_ir_mem [DEPTH];
   logic [AW-1:0]  r_pc_mem [DEPTH];
   logic [PW-1:0]  r_wptr;
   logic [PW-1:0]  r_rptr;
   logic [CW-1:0]  r_count;

   logic [CW:0]    w_used;
   logic           w_issue;
   logic           w_push;
   logic           w_pop;
   logic           w_valid;

   // Issue credit: queued entries plus the outstanding request must leave
   // room, so every response always has a slot waiting for it.
   always_comb begin
      w_used  = {1'b0, r_count} + (CW+1)'(r_inflight);
      w_issue = !rst && !halt && !redirect && (w_used < (CW+1)'(DEPTH));
      w_valid = (r_count != '0);
      w_push  = r_inflight && !redirect;
      w_pop   = w_valid && out_ready;
   end

   // Output drive; head entry is masked to zero while the queue is empty.
   always_comb begin
      imem_req  = w_issue;
      imem_addr = r_pc;
      out_valid = w_valid;
      count     = r_count;
      out_ir    = w_valid ? r_ir_mem[r_rptr] : '0;
      out_pc    = w_valid ? r_pc_mem[r_rptr] : '0;
   end

   // PC and outstanding-request tracking; redirect overrides sequential issue.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_pc;
         end
         if (redirect) begin
            r_pc <= redirect_pc;
         end else if (w_issue) begin
            r_pc <= r_pc + AW'(1);
         end
      end
   end

   // Queue pointers and occupancy; a flush discards everything at once.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (redirect) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage; contents are only visible through the masked head read.
   always_ff @(posedge clk1) begin
      if (w_push) begin
         r_ir_mem[r_wptr] <= imem_rdata;
         r_pc_mem[r_wptr] <= r_inflight_pc;
      end
   end

endmodule

// File: tb/tb_acc16_fetch_queue.sv
// Bench for acc16_fetch_queue: memory model, in-order stream model checked
// every cycle, and directed timing checks for each scenario.
module tb_acc16_fetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 16;
   localparam int CW    = $clog2(DEPTH+1);

   logic           clk1;
   logic           rst;
   logic           imem_req;
   logic [AW-1:0]  imem_addr;
   logic [15:0]    imem_rdata;
   logic           redirect;
   logic [AW-1:0]  redirect_pc;
   logic           halt;
   logic           out_valid;
   logic           out_ready;
   logic [15:0]    out_ir;
   logic [AW-1:0]  out_pc;
   logic [CW-1:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   acc16_fetch_queue #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .RESET_PC (16'h0000)
   ) dut (
      .clk1        (clk1),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ir      (out_ir),
      .out_pc      (out_pc),
      .count       (count)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h5006;
         16'h0001: return 16'hB401;
         16'h0002: return 16'h0000;
         16'h0006: return 16'h2800;
         default:  return {a[7:0] ^ 8'h5A, a[15:8] + 8'h3C};
      endcase
   endfunction

   // Synchronous instruction memory; garbage when no request was made.
   always @(posedge clk1) begin
      imem_rdata <= imem_req ? mem_f(imem_addr) : 16'hDEAD;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Stream model: delivered pcs are consecutive from the reset pc or the
   // latest redirect target, each carrying the memory word at that pc.
   logic [15:0] m_next = 16'h0000;
   logic        p_hold = 1'b0;
   logic [15:0] p_ir;
   logic [15:0] p_pc;

   always @(negedge clk1) begin
      if (rst) begin
         chk("rst_valid", 32'(out_valid), 0);
         chk("rst_req",   32'(imem_req),  0);
         chk("rst_count", 32'(count),     0);
         m_next = 16'h0000;
         p_hold = 1'b0;
      end else begin
         if (p_hold) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_pc",    32'(out_pc),    32'(p_pc));
            chk("hold_ir",    32'(out_ir),    32'(p_ir));
         end
         chk("valid_vs_count", 32'(out_valid), 32'(count != 0));
         chk("count_bound",    32'(count <= 3'(DEPTH)), 1);
         if (halt || redirect) chk("req_gate", 32'(imem_req), 0);
         if (out_valid) begin
            chk("stream_pc", 32'(out_pc), 32'(m_next));
            chk("stream_ir", 32'(out_ir), 32'(mem_f(out_pc)));
         end
         if (out_valid && out_ready) m_next = m_next + 16'd1;
         if (redirect) m_next = redirect_pc;
         p_hold = out_valid && !out_ready && !redirect;
         p_pc   = out_pc;
         p_ir   = out_ir;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk1);
      #1;
   endtask

   task automatic samp();
      #3;
   endtask

   task automatic startup_checks(input string tag);
      samp();
      chk({tag, "_c0_req"},   32'(imem_req),  1);
      chk({tag, "_c0_addr"},  32'(imem_addr), 0);
      chk({tag, "_c0_valid"}, 32'(out_valid), 0);
      chk({tag, "_c0_count"}, 32'(count),     0);
      cyc(); samp();
      chk({tag, "_c1_valid"}, 32'(out_valid), 0);
      cyc(); samp();
      chk({tag, "_c2_valid"}, 32'(out_valid), 1);
      chk({tag, "_c2_pc"},    32'(out_pc),    'h0000);
      chk({tag, "_c2_ir"},    32'(out_ir),    'h5006);
      cyc(); samp();
      chk({tag, "_c3_pc"},    32'(out_pc),    'h0001);
      chk({tag, "_c3_ir"},    32'(out_ir),    'hB401);
   endtask

   initial begin
      rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      repeat (3) cyc();

      // Startup
      rst = 1'b0;
      startup_checks("start");
      cyc(); samp();
      chk("start_c4_pc", 32'(out_pc), 'h0002);
      chk("start_c4_ir", 32'(out_ir), 'h0000);
      repeat (3) cyc();

      // Backpressure until the queue fills
      cyc(); out_ready = 1'b0;
      repeat (9) cyc();
      samp();
      chk("bp_count", 32'(count),     4);
      chk("bp_req",   32'(imem_req),  0);
      chk("bp_valid", 32'(out_valid), 1);

      // Single pop from a full queue re-opens issue next cycle
      cyc(); out_ready = 1'b1; samp();
      chk("full_req",   32'(imem_req), 0);
      chk("full_count", 32'(count),    4);
      cyc(); out_ready = 1'b0; samp();
      chk("pop1_count", 32'(count),    3);
      chk("pop1_req",   32'(imem_req), 1);
      cyc(); samp();
      chk("pop2_req",   32'(imem_req), 0);
      chk("pop2_count", 32'(count),    3);
      cyc(); samp();
      chk("pop3_count", 32'(count),    4);
      cyc(); out_ready = 1'b1;
      repeat (8) cyc();

      // Halt drains the queue without new requests
      cyc(); halt = 1'b1; samp();
      chk("halt_req0", 32'(imem_req), 0);
      for (int i = 0; i < 5; i++) begin
         cyc(); samp();
         chk("halt_req", 32'(imem_req), 0);
      end
      chk("halt_count", 32'(count), 0);

      // Resume under backpressure, then redirect with 2 queued + 1 in flight
      cyc(); halt = 1'b0; out_ready = 1'b0; samp();
      chk("resume_req", 32'(imem_req), 1);
      cyc(); cyc();
      cyc(); redirect = 1'b1; redirect_pc = 16'h0006; samp();
      chk("redir_pre_count", 32'(count),     2);
      chk("redir_pre_req",   32'(imem_req),  0);
      chk("redir_pre_valid", 32'(out_valid), 1);
      cyc(); redirect = 1'b0; out_ready = 1'b1; samp();
      chk("redir_t1_valid", 32'(out_valid), 0);
      chk("redir_t1_req",   32'(imem_req),  1);
      chk("redir_t1_addr",  32'(imem_addr), 'h0006);
      cyc(); samp();
      chk("redir_t2_valid", 32'(out_valid), 0);
      cyc(); samp();
      chk("redir_t3_valid", 32'(out_valid), 1);
      chk("redir_t3_pc",    32'(out_pc),    'h0006);
      chk("redir_t3_ir",    32'(out_ir),    'h2800);
      repeat (3) cyc();

      // PC wrap
      cyc(); redirect = 1'b1; redirect_pc = 16'hFFFE;
      cyc(); redirect = 1'b0;
      cyc();
      cyc(); samp();
      chk("wrap_pc0", 32'(out_pc), 'hFFFE);
      cyc(); samp();
      chk("wrap_pc1", 32'(out_pc), 'hFFFF);
      cyc(); samp();
      chk("wrap_pc2", 32'(out_pc), 'h0000);

      // Asynchronous reset mid-stream with 3 entries queued
      cyc(); out_ready = 1'b0;
      for (int i = 0; i < 20 && count != 3; i++) cyc();
      chk("reach_count3", 32'(count), 3);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_req",   32'(imem_req),  0);
      chk("arst_count", 32'(count),     0);
      chk("arst_ir",    32'(out_ir),    0);
      chk("arst_pc",    32'(out_pc),    0);
      repeat (2) cyc();
      rst = 1'b0; out_ready = 1'b1;
      startup_checks("restart");
      repeat (3) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
